ram8_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of one RAM8 (8 x 16-bit register file: write on clock edge when load=1, read combinational).
- Shares the single RAM8 port between requester A and requester B with a one-cycle valid/grant handshake.
- Optionally walks all 8 words to a clear value after reset, or on command.
- Drives the RAM8 in/load/address pins directly; RAM8 out feeds back into this block.

---
 rtl/ram8_arbiter.sv | 130 +++++++++++++
 tb/tb_ram8_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: round-robin arbiter and clear sequencer in front of one RAM8
// (8 x 16-bit register file, synchronous write, combinational read).
//
// State table:
//   state    | meaning
//   ST_CLEAR | walk words 0..7 writing CLEAR_VALUE, no grants, busy=1
//   ST_ARB   | grant at most one requester per cycle, round-robin on ties
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   clr_req               request a full clear (honoured only in ST_ARB)
//   req_x/we_x/addr_x/wdata_x  requester x transaction (x = a, b)
//   gnt_x                 requester x accepted this cycle (combinational)
//   rvalid_x              rdata holds requester x read result (1-cycle pulse)
//   rdata                 registered read data, shared
//   busy                  high while clearing
//   ram_in/ram_load/ram_address  drive the RAM8
//   ram_out               RAM8 read data
module ram8_arbiter #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_req,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [2:0]  addr_a,
  input  logic [15:0] wdata_a,
  output logic        gnt_a,
  output logic        rvalid_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [2:0]  addr_b,
  input  logic [15:0] wdata_b,
  output logic        gnt_b,
  output logic        rvalid_b,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic [2:0]  ram_address,
  input  logic [15:0] ram_out
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_t;

  state_t     state, next_state;
  logic [2:0] clr_cnt;
  logic       last_gnt_b;   // 1 when B won the most recent grant

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (clr_cnt == 3'd7) next_state = ST_ARB;
      ST_ARB:   if (clr_req)         next_state = ST_CLEAR;
      default:  next_state = ST_ARB;
    endcase
  end

  // Outputs are forced idle while rst_n is low, even though the state
  // register already holds ST_CLEAR during reset.
  always_comb begin
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    busy        = 1'b0;
    ram_load    = 1'b0;
    ram_address = addr_a;
    ram_in      = wdata_a;
    if (rst_n) begin
      case (state)
        ST_CLEAR: begin
          busy        = 1'b1;
          ram_load    = 1'b1;
          ram_address = clr_cnt;
          ram_in      = CLEAR_VALUE;
        end
        ST_ARB: begin
          if (!clr_req) begin
            // On a tie A wins only if B had the previous grant.
            if (req_a && (!req_b || last_gnt_b)) begin
              gnt_a       = 1'b1;
              ram_load    = we_a;
              ram_address = addr_a;
              ram_in      = wdata_a;
            end else if (req_b) begin
              gnt_b       = 1'b1;
              ram_load    = we_b;
              ram_address = addr_b;
              ram_in      = wdata_b;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt    <= 3'd0;
      last_gnt_b <= 1'b1;
      rdata      <= 16'h0000;
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
    end else begin
      // Counter wraps 7 -> 0 on the last clear cycle.
      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 3'd1 : 3'd0;
      if (gnt_a) begin
        last_gnt_b <= 1'b0;
      end else if (gnt_b) begin
        last_gnt_b <= 1'b1;
      end
      if ((gnt_a && !we_a) || (gnt_b && !we_b)) begin
        rdata <= ram_out;
      end
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
module tb_ram8_arbiter;
  localparam logic [15:0] CLR_VAL = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [2:0]  addr_a = 3'd0, addr_b = 3'd0;
  logic [15:0] wdata_a = 16'h0, wdata_b = 16'h0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_load;
  logic [15:0] rdata, ram_in, ram_out;
  logic [2:0]  ram_address;

  ram8_arbiter #(.CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .rdata(rdata), .busy(busy), .ram_in(ram_in), .ram_load(ram_load),
    .ram_address(ram_address), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // RAM8 behavioural model
  logic [15:0] mem [8];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'hFFFF;
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end
  assign ram_out = mem[ram_address];

  // Reference model state
  logic [15:0] ref_mem [8];
  bit          tb_last_b;
  int          n_tests = 0;
  int          n_fail  = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) ref_mem[i] = CLR_VAL;
  endtask

  // Single transaction on one port; entered and left at posedge+1.
  task automatic xfer(input bit pb, input bit we, input logic [2:0] addr,
                      input logic [15:0] wd, output bit granted,
                      output bit rv, output logic [15:0] rd);
    if (pb) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; end
    else    begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wd; end
    @(negedge clk);
    granted = pb ? gnt_b : gnt_a;
    @(posedge clk); #1;
    rv = pb ? rvalid_b : rvalid_a;
    rd = rdata;
    req_a = 0; req_b = 0;
    if (granted) begin
      tb_last_b = pb;
      if (we) ref_mem[addr] = wd;
    end
  endtask

  task automatic test_reset();
    bit g, rv; logic [15:0] rd;
    rst_n = 0; preload = 1; req_a = 1; we_a = 0;
    @(posedge clk); #1; preload = 0;
    @(negedge clk);
    n_tests++;
    if ({gnt_a, ram_load, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got gnt/load/busy=%b expected 000", {gnt_a, ram_load, busy});
    end
    n_tests++;
    if ({rvalid_a, rvalid_b, rdata} !== 18'h0) begin
      n_fail++; $display("FAIL reset_regs: got rv=%b%b rdata=%h expected 00 0000", rvalid_a, rvalid_b, rdata);
    end
    req_a = 0;
    @(posedge clk); #1; rst_n = 1; tb_last_b = 1; ref_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || ram_load !== 1'b1 || ram_address !== 3'(i)) begin
        n_fail++; $display("FAIL reset_clear_step%0d: got busy=%b load=%b addr=%0d expected 1 1 %0d", i, busy, ram_load, ram_address, i);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_clear_len: got busy=%b expected 0 after 8 cycles", busy);
    end
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      xfer(0, 0, 3'(a), 16'h0, g, rv, rd);
      n_tests++;
      if ({g, rv, rd} !== {1'b1, 1'b1, ref_mem[a]}) begin
        n_fail++; $display("FAIL reset_readback%0d: got g=%b rv=%b data=%h expected 1 1 %h", a, g, rv, rd, ref_mem[a]);
      end
    end
  endtask

  task automatic test_rw();
    bit g, rv; logic [15:0] rd;
    xfer(0, 1, 3'd5, 16'h1234, g, rv, rd);
    n_tests++;
    if ({g, rv, rvalid_b} !== 3'b100) begin
      n_fail++; $display("FAIL rw_write: got g=%b rva=%b rvb=%b expected 1 0 0", g, rv, rvalid_b);
    end
    xfer(0, 0, 3'd5, 16'h0, g, rv, rd);
    n_tests++;
    if ({g, rv, rvalid_b, rd} !== {3'b110, 16'h1234}) begin
      n_fail++; $display("FAIL rw_read: got g=%b rva=%b rvb=%b data=%h expected 1 1 0 1234", g, rv, rvalid_b, rd);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({rvalid_a, rdata} !== {1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL rw_hold: got rva=%b data=%h expected 0 1234", rvalid_a, rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit g, rv, exp_b; logic [15:0] rd;
    int ia = 0, ib = 0;
    xfer(1, 0, 3'd0, 16'h0, g, rv, rd);
    n_tests++;
    if ({g, rv, rd} !== {1'b1, 1'b1, ref_mem[0]}) begin
      n_fail++; $display("FAIL b2b_pre_read: got g=%b rv=%b data=%h expected 1 1 %h", g, rv, rd, ref_mem[0]);
    end
    for (int cyc = 0; cyc < 12 && (ia < 4 || ib < 4); cyc++) begin
      req_a = (ia < 4); we_a = 1; addr_a = 3'(ia); wdata_a = 16'h00A0 + 16'(ia);
      req_b = (ib < 4); we_b = 1; addr_b = 3'(ib + 4); wdata_b = 16'h00B0 + 16'(ib);
      exp_b = (req_a && req_b) ? !tb_last_b : req_b;
      @(negedge clk);
      n_tests++;
      if ({gnt_a, gnt_b, ram_load} !== {!exp_b, exp_b, 1'b1} ||
          ram_address !== (exp_b ? addr_b : addr_a)) begin
        n_fail++; $display("FAIL b2b_order%0d: got ga=%b gb=%b load=%b addr=%0d expected %b %b 1 %0d", cyc, gnt_a, gnt_b, ram_load, ram_address, !exp_b, exp_b, exp_b ? addr_b : addr_a);
      end
      if (gnt_a) begin ref_mem[addr_a] = wdata_a; tb_last_b = 0; ia++; end
      else if (gnt_b) begin ref_mem[addr_b] = wdata_b; tb_last_b = 1; ib++; end
      @(posedge clk); #1;
    end
    req_a = 0; req_b = 0;
    n_tests++;
    if (ia != 4 || ib != 4) begin
      n_fail++; $display("FAIL b2b_done: got ia=%0d ib=%0d expected 4 4", ia, ib);
    end
    for (int a = 0; a < 8; a++) begin
      xfer(a[0], 0, 3'(a), 16'h0, g, rv, rd);
      n_tests++;
      if ({g, rv, rd} !== {1'b1, 1'b1, (a < 4) ? 16'h00A0 + 16'(a) : 16'h00B0 + 16'(a - 4)}) begin
        n_fail++; $display("FAIL b2b_readback%0d: got g=%b rv=%b data=%h expected 1 1 %h", a, g, rv, rd, ref_mem[a]);
      end
    end
  endtask

  task automatic test_clear_wait();
    clr_req = 1;
    @(negedge clk);
    n_tests++;
    if ({gnt_a, gnt_b, ram_load, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL cw_start: got ga/gb/load/busy=%b expected 0000", {gnt_a, gnt_b, ram_load, busy});
    end
    @(posedge clk); #1;
    clr_req = 0; req_b = 1; we_b = 0; addr_b = 3'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (gnt_b !== 1'b0 || busy !== 1'b1 || ram_address !== 3'(i)) begin
        n_fail++; $display("FAIL cw_step%0d: got gb=%b busy=%b addr=%0d expected 0 1 %0d", i, gnt_b, busy, ram_address, i);
      end
      @(posedge clk); #1;
    end
    ref_clear();
    @(negedge clk);
    n_tests++;
    if ({gnt_b, busy} !== 2'b10) begin
      n_fail++; $display("FAIL cw_grant: got gb=%b busy=%b expected 1 0", gnt_b, busy);
    end
    @(posedge clk); #1;
    req_b = 0; tb_last_b = 1;
    n_tests++;
    if ({rvalid_b, rdata} !== {1'b1, ref_mem[2]}) begin
      n_fail++; $display("FAIL cw_read: got rvb=%b data=%h expected 1 %h", rvalid_b, rdata, ref_mem[2]);
    end
  endtask

  task automatic test_clr_priority();
    bit g, rv, got; logic [15:0] rd; int cnt;
    xfer(0, 1, 3'd3, 16'hBEEF, g, rv, rd);
    n_tests++;
    if (g !== 1'b1) begin
      n_fail++; $display("FAIL cp_write: got g=%b expected 1", g);
    end
    clr_req = 1; req_a = 1; we_a = 0; addr_a = 3'd3;
    @(negedge clk);
    n_tests++;
    if ({gnt_a, gnt_b, ram_load} !== 3'b000) begin
      n_fail++; $display("FAIL cp_nogrant: got ga/gb/load=%b expected 000", {gnt_a, gnt_b, ram_load});
    end
    @(posedge clk); #1;
    clr_req = 0; cnt = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt_a) got = 1;
      else if (busy) cnt++;
      @(posedge clk); #1;
    end
    req_a = 0; ref_clear(); tb_last_b = 0;
    n_tests++;
    if (!got || cnt != 8) begin
      n_fail++; $display("FAIL cp_clear_len: got granted=%b clear_cycles=%0d expected 1 8", got, cnt);
    end
    n_tests++;
    if ({rvalid_a, rdata} !== {1'b1, ref_mem[3]}) begin
      n_fail++; $display("FAIL cp_read: got rva=%b data=%h expected 1 %h", rvalid_a, rdata, ref_mem[3]);
    end
  endtask

  task automatic test_reset_mid_clear();
    clr_req = 1;
    @(posedge clk); #1;
    clr_req = 0; req_a = 1; we_a = 0; addr_a = 3'd6;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    n_tests++;
    if ({busy, ram_address} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL rmc_pos: got busy=%b addr=%0d expected 1 3", busy, ram_address);
    end
    rst_n = 0; #1;
    n_tests++;
    if ({busy, ram_load, gnt_a} !== 3'b000) begin
      n_fail++; $display("FAIL rmc_async: got busy/load/ga=%b expected 000", {busy, ram_load, gnt_a});
    end
    @(posedge clk); #1;
    rst_n = 1; tb_last_b = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || gnt_a !== 1'b0 || ram_address !== 3'(i)) begin
        n_fail++; $display("FAIL rmc_step%0d: got busy=%b ga=%b addr=%0d expected 1 0 %0d", i, busy, gnt_a, ram_address, i);
      end
      @(posedge clk); #1;
    end
    ref_clear();
    @(negedge clk);
    n_tests++;
    if (gnt_a !== 1'b1) begin
      n_fail++; $display("FAIL rmc_grant: got ga=%b expected 1", gnt_a);
    end
    @(posedge clk); #1;
    req_a = 0; tb_last_b = 0;
    n_tests++;
    if ({rvalid_a, rdata} !== {1'b1, ref_mem[6]}) begin
      n_fail++; $display("FAIL rmc_read: got rva=%b data=%h expected 1 %h", rvalid_a, rdata, ref_mem[6]);
    end
  endtask

  task automatic test_reset_mid_read();
    bit g, rv, done; logic [15:0] rd; int cnt;
    xfer(0, 1, 3'd0, 16'h5A5A, g, rv, rd);
    xfer(0, 0, 3'd0, 16'h0, g, rv, rd);
    n_tests++;
    if ({g, rv, rd} !== {2'b11, 16'h5A5A}) begin
      n_fail++; $display("FAIL rmr_read: got g=%b rv=%b data=%h expected 1 1 5a5a", g, rv, rd);
    end
    rst_n = 0; #1;
    n_tests++;
    if ({rvalid_a, rdata} !== 17'h0) begin
      n_fail++; $display("FAIL rmr_lost: got rva=%b data=%h expected 0 0000", rvalid_a, rdata);
    end
    @(posedge clk); #1;
    rst_n = 1; tb_last_b = 1; cnt = 0; done = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (busy) cnt++; else done = 1;
      @(posedge clk); #1;
    end
    ref_clear();
    n_tests++;
    if (!done || cnt != 8) begin
      n_fail++; $display("FAIL rmr_clear_len: got done=%b cycles=%0d expected 1 8", done, cnt);
    end
    xfer(0, 0, 3'd1, 16'h0, g, rv, rd);
    n_tests++;
    if ({g, rv, rd} !== {2'b11, ref_mem[1]}) begin
      n_fail++; $display("FAIL rmr_after: got g=%b rv=%b data=%h expected 1 1 %h", g, rv, rd, ref_mem[1]);
    end
  endtask

  task automatic test_random();
    bit win_a, win_b, rd_a, rd_b;
    logic [15:0] exp_rdata;
    exp_rdata = ref_mem[1];
    for (int cyc = 0; cyc < 200; cyc++) begin
      req_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
      addr_a = 3'($urandom_range(0, 7)); wdata_a = 16'($urandom);
      req_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
      addr_b = 3'($urandom_range(0, 7)); wdata_b = 16'($urandom);
      win_a = req_a && (!req_b || tb_last_b);
      win_b = req_b && !win_a;
      @(negedge clk);
      n_tests++;
      if ({gnt_a, gnt_b} !== {win_a, win_b} ||
          ram_load !== ((win_a && we_a) || (win_b && we_b)) ||
          ((win_a || win_b) && ram_address !== (win_a ? addr_a : addr_b))) begin
        n_fail++; $display("FAIL rand_grant%0d: got ga=%b gb=%b load=%b addr=%0d expected %b %b %b %0d", cyc, gnt_a, gnt_b, ram_load, ram_address, win_a, win_b, (win_a && we_a) || (win_b && we_b), win_a ? addr_a : addr_b);
      end
      rd_a = win_a && !we_a;
      rd_b = win_b && !we_b;
      if (win_a) begin
        tb_last_b = 0;
        if (we_a) ref_mem[addr_a] = wdata_a; else exp_rdata = ref_mem[addr_a];
      end else if (win_b) begin
        tb_last_b = 1;
        if (we_b) ref_mem[addr_b] = wdata_b; else exp_rdata = ref_mem[addr_b];
      end
      @(posedge clk); #1;
      n_tests++;
      if ({rvalid_a, rvalid_b, rdata} !== {rd_a, rd_b, exp_rdata}) begin
        n_fail++; $display("FAIL rand_read%0d: got rva=%b rvb=%b data=%h expected %b %b %h", cyc, rvalid_a, rvalid_b, rdata, rd_a, rd_b, exp_rdata);
      end
    end
    req_a = 0; req_b = 0;
  endtask

  initial begin
    test_reset();
    test_rw();
    test_back_to_back();
    test_clear_wait();
    test_clr_priority();
    test_reset_mid_clear();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
